serial_tx: RTL and testbench
============================

Name: serial_tx

Overview:
Parallel-in, serial-out transmitter that drives a one-bit serial data line into a downstream D-flip-flop shift-register receiver.
- Upstream side: accepts a parallel word through a valid/ready handshake.
- Downstream side: shifts the word out one bit per clock, with an optional even-parity bit.
- Outputs per-bit valid and last-bit strobes so the receiver frames words without a gap.

Parameters:
WIDTH, 8, data word width in bits; legal range is WIDTH >= 2.
MSB_FIRST, 1, 1 = send bit WIDTH-1 first, 0 = send bit 0 first.
PARITY_EN, 0, 1 = append an even-parity bit after the data bits.

Ports:
clock  input  1  system clock, rising-edge active.
reset  input  1  asynchronous, active-high reset.
load_valid  input  1  upstream presents a word on load_data.
load_data  input  WIDTH  word to transmit; sampled only on an accept edge.
load_ready  output  1  transmitter can accept a word this cycle.
sd  output  1  serial data bit; forced to 0 when sd_valid=0.
sd_valid  output  1  sd carries a frame bit this cycle.
sd_last  output  1  current bit is the final bit of the frame.
busy  output  1  a frame is in progress.

Behaviour:
Interface rules:
- One clock: clock. Reset is asynchronous and active-high: reset.
- All outputs except load_ready are registered.
- load_ready = (state==IDLE) | (sd_valid & sd_last). It is combinational from registered state only, with no path from load_valid.

Reset:
- While reset is high, outputs go immediately to sd=0, sd_valid=0, sd_last=0, busy=0, and state=IDLE.
- Hence load_ready=1 during reset.
- The bit counter and shift register clear to 0.

Accept:
- A word is accepted on a rising edge where load_valid & load_ready = 1.
- On that edge: load_data is latched, the parity is computed as the XOR of all data bits, and the counter is cleared.
- load_data changes after accept have no effect on the frame.

States:
- IDLE: sd_valid=0, busy=0. Accept -> DATA.
- DATA: one bit per cycle, taken from the latched word in MSB_FIRST order; counter increments each cycle.
  - Counter == WIDTH-1 and PARITY_EN=0: sd_last=1. Next edge -> DATA if accept, else IDLE.
  - Counter == WIDTH-1 and PARITY_EN=1: sd_last=0. Next edge -> PARITY.
- PARITY: sd = even parity, sd_last=1. Next edge -> DATA if accept, else IDLE.

Frame timing:
- Latency: accept at edge N puts the first bit on sd in the cycle after edge N.
- Frame length is exactly WIDTH+PARITY_EN consecutive sd_valid cycles.
- busy=1 for exactly those cycles.

Back-to-back frames:
- An accept during the last-bit cycle loads the next word.
- Its first bit appears in the very next cycle, so sd_valid stays 1 with no idle gap.

Boundary conditions:
- load_valid low in the last-bit cycle: return to IDLE, sd_valid=0 next cycle.
- load_valid high mid-frame: no effect; load_ready=0 and the word is not consumed.
- Reset asserted mid-frame: the frame is abandoned immediately with no partial completion; outputs take reset values asynchronously.
- First accept after reset is released: behaves identically to a fresh IDLE accept.
- sd_valid=0: sd must be 0, and sd_last must be 0.

Test Plan:
1. Single frame, WIDTH=8, MSB_FIRST=1, PARITY_EN=0: load 0xA5, one-cycle valid.
   - sd = 1,0,1,0,0,1,0,1 over 8 cycles starting the cycle after accept.
   - sd_last on the 8th bit; busy high 8 cycles; load_ready returns to 1.
2. PARITY_EN=1:
   - Load 0xA5 -> 9 bits, final parity bit sd=0, sd_last on bit 9.
   - Load 0x07 -> final parity bit sd=1.
3. Back-to-back: load_valid held high with 0x0F then 0xF0.
   - Continuous 16 sd_valid cycles: 0,0,0,0,1,1,1,1,1,1,1,1,0,0,0,0.
   - sd_last on cycles 8 and 16; no gap.
4. MSB_FIRST=0: load 0x01 -> sd = 1,0,0,0,0,0,0,0.
5. Mid-frame stimulus: change load_data and pulse load_valid during bit 3 of a 0xC3 frame.
   - Transmitted bits unchanged (1,1,0,0,0,0,1,1); load_ready stays 0 until the last-bit cycle.
6. Reset mid-frame: assert reset asynchronously (off clock edge) during bit 4.
   - sd, sd_valid, sd_last and busy drop to 0 immediately; load_ready=1.
   - After release, loading 0x81 yields a clean 1,0,0,0,0,0,0,1 frame.

Source files
------------

// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out transmitter with a valid/ready load
// handshake, optional trailing even-parity bit, and per-bit valid/last
// strobes so a downstream shift-register receiver can frame words gap-free.
module serial_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sd,
  output logic             sd_valid,
  output logic             sd_last,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             sd_q, sd_d;
  logic             sd_valid_q, sd_valid_d;
  logic             sd_last_q, sd_last_d;
  logic             busy_q, busy_d;

  logic             accept;
  logic             frame_end;
  logic [CNT_W-1:0] cnt_inc;

  // The bit that goes on the line next, in the configured order.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // The word with its next-to-send bit consumed.
  function automatic logic [WIDTH-1:0] consume(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Ready in idle or during the final bit, so the next word chains on without a gap.
  assign load_ready = (state_q == IDLE) | (sd_valid_q & sd_last_q);
  assign accept     = load_valid & load_ready;
  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign frame_end  = ((state_q == DATA) && (cnt_q == CNT_LAST) && !PARITY_EN)
                    || (state_q == PARITY);

  // Next-state and registered-output computation for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    sd_d       = sd_q;
    sd_valid_d = sd_valid_q;
    sd_last_d  = sd_last_q;
    busy_d     = busy_q;

    if ((state_q == IDLE) || frame_end) begin
      if (accept) begin
        state_d    = DATA;
        cnt_d      = '0;
        shift_d    = consume(load_data);
        parity_d   = ^load_data;
        sd_d       = first_bit(load_data);
        sd_valid_d = 1'b1;
        sd_last_d  = 1'b0;
        busy_d     = 1'b1;
      end else begin
        state_d    = IDLE;
        sd_d       = 1'b0;
        sd_valid_d = 1'b0;
        sd_last_d  = 1'b0;
        busy_d     = 1'b0;
      end
    end else if (state_q == DATA) begin
      if (cnt_q == CNT_LAST) begin
        state_d    = PARITY;
        sd_d       = parity_q;
        sd_valid_d = 1'b1;
        sd_last_d  = 1'b1;
        busy_d     = 1'b1;
      end else begin
        cnt_d      = cnt_inc;
        shift_d    = consume(shift_q);
        sd_d       = first_bit(shift_q);
        sd_valid_d = 1'b1;
        sd_last_d  = !PARITY_EN && (cnt_inc == CNT_LAST);
        busy_d     = 1'b1;
      end
    end
  end

  // State and output registers; reset abandons any frame immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      sd_q       <= 1'b0;
      sd_valid_q <= 1'b0;
      sd_last_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      sd_q       <= sd_d;
      sd_valid_q <= sd_valid_d;
      sd_last_q  <= sd_last_d;
      busy_q     <= busy_d;
    end
  end

  assign sd       = sd_q;
  assign sd_valid = sd_valid_q;
  assign sd_last  = sd_last_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed bench for serial_tx across three configurations
// (MSB-first plain, MSB-first with parity, LSB-first plain).
module tb_serial_tx;

  logic       clock;
  logic       reset;
  logic [2:0] load_valid_v;
  logic [7:0] load_data_v [3];
  logic [2:0] load_ready_v;
  logic [2:0] sd_v;
  logic [2:0] sd_valid_v;
  logic [2:0] sd_last_v;
  logic [2:0] busy_v;

  logic [1:0] sel;
  logic       load_ready_s, sd_s, sd_valid_s, sd_last_s, busy_s;

  int vec_count;
  int miss_count;

  typedef struct {
    logic [1:0] cfg;
    logic [7:0] data;
    int         nbits;
    logic [8:0] seq;
    int         poke_bit;
  } vec_t;

  vec_t vecs [6];

  serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) dut_msb (
    .clock(clock), .reset(reset),
    .load_valid(load_valid_v[0]), .load_data(load_data_v[0]),
    .load_ready(load_ready_v[0]), .sd(sd_v[0]), .sd_valid(sd_valid_v[0]),
    .sd_last(sd_last_v[0]), .busy(busy_v[0])
  );

  serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut_par (
    .clock(clock), .reset(reset),
    .load_valid(load_valid_v[1]), .load_data(load_data_v[1]),
    .load_ready(load_ready_v[1]), .sd(sd_v[1]), .sd_valid(sd_valid_v[1]),
    .sd_last(sd_last_v[1]), .busy(busy_v[1])
  );

  serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) dut_lsb (
    .clock(clock), .reset(reset),
    .load_valid(load_valid_v[2]), .load_data(load_data_v[2]),
    .load_ready(load_ready_v[2]), .sd(sd_v[2]), .sd_valid(sd_valid_v[2]),
    .sd_last(sd_last_v[2]), .busy(busy_v[2])
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Route the outputs of the configuration under test to common names.
  always_comb begin
    load_ready_s = load_ready_v[sel];
    sd_s         = sd_v[sel];
    sd_valid_s   = sd_valid_v[sel];
    sd_last_s    = sd_last_v[sel];
    busy_s       = busy_v[sel];
  end

  task automatic applyStimulus(input logic [1:0] cfg, input logic valid,
                               input logic [7:0] data);
    sel          = cfg;
    load_valid_v = 3'b000;
    load_valid_v[cfg] = valid;
    load_data_v[cfg]  = data;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " sd_valid"},   32'(sd_valid_s),   32'd0);
    checkOutput({tag, " sd"},         32'(sd_s),         32'd0);
    checkOutput({tag, " sd_last"},    32'(sd_last_s),    32'd0);
    checkOutput({tag, " busy"},       32'(busy_s),       32'd0);
    checkOutput({tag, " load_ready"}, 32'(load_ready_s), 32'd1);
  endtask

  task automatic checkBit(input string tag, input int i, input logic exp_sd,
                          input logic exp_last);
    checkOutput($sformatf("%s bit%0d sd_valid", tag, i),   32'(sd_valid_s),   32'd1);
    checkOutput($sformatf("%s bit%0d sd", tag, i),         32'(sd_s),         32'(exp_sd));
    checkOutput($sformatf("%s bit%0d sd_last", tag, i),    32'(sd_last_s),    32'(exp_last));
    checkOutput($sformatf("%s bit%0d busy", tag, i),       32'(busy_s),       32'd1);
    checkOutput($sformatf("%s bit%0d load_ready", tag, i), 32'(load_ready_s), 32'(exp_last));
  endtask

  // One full frame starting and ending in idle; seq[8] is the first bit sent.
  task automatic runFrame(input vec_t v);
    string tag;
    tag = $sformatf("cfg%0d data%02h", v.cfg, v.data);
    applyStimulus(v.cfg, 1'b1, v.data);
    checkOutput({tag, " ready before accept"}, 32'(load_ready_s), 32'd1);
    @(posedge clock);
    @(negedge clock);
    applyStimulus(v.cfg, 1'b0, ~v.data);
    for (int i = 0; i < v.nbits; i++) begin
      if (i == v.poke_bit) applyStimulus(v.cfg, 1'b1, 8'h3C);
      if (i == v.poke_bit + 1) applyStimulus(v.cfg, 1'b0, 8'h3C);
      checkBit(tag, i, v.seq[8-i], i == v.nbits - 1);
      @(negedge clock);
    end
    checkIdle({tag, " after"});
  endtask

  initial begin
    vec_count    = 0;
    miss_count   = 0;
    reset        = 1'b1;
    sel          = 2'd0;
    load_valid_v = 3'b000;
    for (int k = 0; k < 3; k++) load_data_v[k] = 8'h00;

    vecs[0] = '{cfg: 2'd0, data: 8'hA5, nbits: 8, seq: 9'b10100101_0, poke_bit: -10};
    vecs[1] = '{cfg: 2'd1, data: 8'hA5, nbits: 9, seq: 9'b10100101_0, poke_bit: -10};
    vecs[2] = '{cfg: 2'd1, data: 8'h07, nbits: 9, seq: 9'b00000111_1, poke_bit: -10};
    vecs[3] = '{cfg: 2'd2, data: 8'h01, nbits: 8, seq: 9'b10000000_0, poke_bit: -10};
    vecs[4] = '{cfg: 2'd2, data: 8'h0F, nbits: 8, seq: 9'b11110000_0, poke_bit: -10};
    vecs[5] = '{cfg: 2'd0, data: 8'hC3, nbits: 8, seq: 9'b11000011_0, poke_bit: 2};

    // Outputs held at reset values while reset is asserted.
    #12;
    for (int k = 0; k < 3; k++) begin
      sel = 2'(k);
      #1;
      checkIdle($sformatf("reset cfg%0d", k));
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Table-driven single frames, including the mid-frame poke on 0xC3.
    foreach (vecs[n]) begin
      runFrame(vecs[n]);
      @(negedge clock);
    end

    // Back-to-back 0x0F then 0xF0 with load_valid held high.
    begin
      logic [15:0] b2b;
      b2b = 16'b0000_1111_1111_0000;
      applyStimulus(2'd0, 1'b1, 8'h0F);
      @(posedge clock);
      @(negedge clock);
      applyStimulus(2'd0, 1'b1, 8'hF0);
      for (int i = 0; i < 16; i++) begin
        if (i == 8) applyStimulus(2'd0, 1'b0, 8'h55);
        checkBit("b2b", i, b2b[15-i], (i == 7) || (i == 15));
        @(negedge clock);
      end
      checkIdle("b2b after");
    end
    @(negedge clock);

    // Reset asserted off-edge during bit 4, then a clean frame afterwards.
    applyStimulus(2'd0, 1'b1, 8'hA5);
    @(posedge clock);
    @(negedge clock);
    applyStimulus(2'd0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) @(negedge clock);
    checkBit("pre-reset", 3, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkIdle("async reset");
    @(negedge clock);
    checkIdle("held reset");
    reset = 1'b0;
    @(negedge clock);
    checkIdle("post reset");
    runFrame('{cfg: 2'd0, data: 8'h81, nbits: 8, seq: 9'b10000001_0, poke_bit: -10});

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
